// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage with request/ready handshake, load extension, store lane steering and the MEM/WB register.
module memory_stage #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_valid,
  input  logic [ADDR_WIDTH-1:0]   i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0]   i_pc_target,
  input  logic [DATA_WIDTH-1:0]   i_alu_result,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  input  logic [DATA_WIDTH-1:0]   i_imm_ext,
  input  logic [REG_ADDR_W-1:0]   i_rd_addr,
  input  logic [2:0]              i_result_src,
  input  logic                    i_reg_we,
  input  logic                    i_mem_re,
  input  logic                    i_mem_we,
  input  logic [2:0]              i_func3,
  output logic                    o_stall,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                    i_mem_ready,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_valid,
  output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
  output logic [ADDR_WIDTH-1:0]   o_pc_target,
  output logic [DATA_WIDTH-1:0]   o_alu_result,
  output logic [DATA_WIDTH-1:0]   o_imm_ext,
  output logic [DATA_WIDTH-1:0]   o_read_data,
  output logic [REG_ADDR_W-1:0]   o_rd_addr,
  output logic [2:0]              o_result_src,
  output logic                    o_reg_we,
  output logic                    o_access_fault
);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] pc_target;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [2:0]            result_src;
    logic [2:0]            func3;
    logic                  reg_we;
    logic                  mem_re;
    logic                  mem_we;
  } ex_t;
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] pc_target;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [2:0]            result_src;
    logic                  reg_we;
    logic                  access_fault;
  } wb_t;
  state_t state_q, state_d;
  ex_t ex_q, ex_d, ex_in;
  wb_t wb_q, wb_d;
  logic idle, is_mem, bad_op, misaligned, fault, access;
  logic [1:0] in_sz, sz;
  logic [DATA_WIDTH-1:0] lane, load_data, st_data;
  logic [BW-1:0] size_mask;
  assign ex_in = {i_pc_plus4, i_pc_target, i_alu_result, i_write_data, i_imm_ext,
                  i_rd_addr, i_result_src, i_func3, i_reg_we, i_mem_re, i_mem_we};
  assign idle = state_q == IDLE;
  assign in_sz = i_func3[1:0];
  assign is_mem = i_valid & (i_mem_re | i_mem_we);
  assign bad_op = (i_mem_re & i_mem_we) | (i_mem_re & (i_func3 == 3'b111)) | (i_mem_we & i_func3[2]);
  assign misaligned = in_sz == 2'd1 ? i_alu_result[0] :
                      in_sz == 2'd2 ? |i_alu_result[1:0] :
                      in_sz == 2'd3 ? |i_alu_result[2:0] : 1'b0;
  assign fault = is_mem & (bad_op | misaligned);
  assign access = is_mem & ~fault;
  // Stall is gated by reset so every output reads 0 while it is held.
  assign o_stall = ~i_arst & (idle ? access : ~i_mem_ready);
  assign sz = ex_q.func3[1:0];
  assign lane = i_mem_rdata >> {ex_q.alu_result[2:0], 3'b000};
  assign load_data = sz == 2'd0 ? {{(DATA_WIDTH-8){~ex_q.func3[2] & lane[7]}}, lane[7:0]} :
                     sz == 2'd1 ? {{(DATA_WIDTH-16){~ex_q.func3[2] & lane[15]}}, lane[15:0]} :
                     sz == 2'd2 ? {{(DATA_WIDTH-32){~ex_q.func3[2] & lane[31]}}, lane[31:0]} : lane;
  assign st_data = sz == 2'd0 ? {(DATA_WIDTH/8){ex_q.write_data[7:0]}} :
                   sz == 2'd1 ? {(DATA_WIDTH/16){ex_q.write_data[15:0]}} :
                   sz == 2'd2 ? {(DATA_WIDTH/32){ex_q.write_data[31:0]}} : ex_q.write_data;
  assign size_mask = BW'(sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF);
  assign o_mem_req = ~idle;
  assign o_mem_we = ~idle & ex_q.mem_we;
  assign o_mem_addr = idle ? '0 : {ex_q.alu_result[ADDR_WIDTH-1:3], 3'b000};
  assign o_mem_wdata = idle ? '0 : st_data;
  assign o_mem_be = idle ? '0 : size_mask << ex_q.alu_result[2:0];
  always_comb begin
    state_d = state_q;
    ex_d = ex_q;
    wb_d = wb_q;
    if (idle) begin
      wb_d = {i_valid & ~access, i_pc_plus4, i_pc_target, i_alu_result, {DATA_WIDTH{1'b0}},
              i_imm_ext, i_rd_addr, i_result_src, i_valid & i_reg_we & ~fault & ~access, fault};
      if (access) begin
        ex_d = ex_in;
        state_d = WAIT;
      end
    end else if (i_mem_ready) begin
      wb_d = {1'b1, ex_q.pc_plus4, ex_q.pc_target, ex_q.alu_result,
              ex_q.mem_re ? load_data : {DATA_WIDTH{1'b0}},
              ex_q.imm_ext, ex_q.rd_addr, ex_q.result_src, ex_q.reg_we, 1'b0};
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      ex_q <= '0;
      wb_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q <= ex_d;
      wb_q <= wb_d;
    end
  end
  assign o_valid = wb_q.valid;
  assign o_pc_plus4 = wb_q.pc_plus4;
  assign o_pc_target = wb_q.pc_target;
  assign o_alu_result = wb_q.alu_result;
  assign o_imm_ext = wb_q.imm_ext;
  assign o_read_data = wb_q.read_data;
  assign o_rd_addr = wb_q.rd_addr;
  assign o_result_src = wb_q.result_src;
  assign o_reg_we = wb_q.reg_we;
  assign o_access_fault = wb_q.access_fault;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: random and directed accesses checked against a byte-level reference model.
module tb_memory_stage;
  logic i_clk = 0, i_arst = 1;
  logic i_valid = 0, i_reg_we = 0, i_mem_re = 0, i_mem_we = 0, i_mem_ready = 0;
  logic [63:0] i_pc_plus4 = 0, i_pc_target = 0, i_alu_result = 0, i_write_data = 0, i_imm_ext = 0, i_mem_rdata = 0;
  logic [4:0] i_rd_addr = 0;
  logic [2:0] i_result_src = 0, i_func3 = 0;
  logic o_stall, o_mem_req, o_mem_we, o_valid, o_reg_we, o_access_fault;
  logic [63:0] o_mem_addr, o_mem_wdata, o_pc_plus4, o_pc_target, o_alu_result, o_imm_ext, o_read_data;
  logic [7:0] o_mem_be;
  logic [4:0] o_rd_addr;
  logic [2:0] o_result_src;
  int total = 0, bad = 0;
  memory_stage dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_valid(i_valid), .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target),
    .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_imm_ext(i_imm_ext), .i_rd_addr(i_rd_addr),
    .i_result_src(i_result_src), .i_reg_we(i_reg_we), .i_mem_re(i_mem_re), .i_mem_we(i_mem_we),
    .i_func3(i_func3), .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ready(i_mem_ready),
    .i_mem_rdata(i_mem_rdata), .o_valid(o_valid), .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target),
    .o_alu_result(o_alu_result), .o_imm_ext(o_imm_ext), .o_read_data(o_read_data), .o_rd_addr(o_rd_addr),
    .o_result_src(o_result_src), .o_reg_we(o_reg_we), .o_access_fault(o_access_fault)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] a, input logic [2:0] f3);
    int n = 1 << f3[1:0];
    int off = int'(a[2:0]);
    logic [63:0] v = 0;
    for (int i = 0; i < n; i++) v |= ((rd >> (8 * (off + i))) & 64'hFF) << (8 * i);
    if (!f3[2] && n < 8 && v[8*n-1]) v |= ~((64'h1 << (8 * n)) - 1);
    return v;
  endfunction
  function automatic logic [7:0] model_be(input logic [63:0] a, input logic [2:0] f3);
    logic [7:0] be = 0;
    for (int i = 0; i < (1 << f3[1:0]); i++) be[int'(a[2:0]) + i] = 1'b1;
    return be;
  endfunction
  function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [2:0] f3);
    logic [63:0] w = 0;
    int n = 1 << f3[1:0];
    for (int j = 0; j < 8; j++) w |= ((d >> (8 * (j % n))) & 64'hFF) << (8 * j);
    return w;
  endfunction
  task automatic clear_inputs();
    i_valid = 0; i_mem_re = 0; i_mem_we = 0; i_reg_we = 0; i_mem_ready = 0;
  endtask
  // Called at a negedge with the DUT idle; returns at a negedge with the result checked.
  task automatic run(input bit v, input bit re, input bit we, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] rdat, input int dly);
    int n = 1 << f3[1:0];
    bit flt = v && (re || we) && ((re && we) || (re && f3 == 3'b111) || (we && f3[2]) || (a % n != 0));
    bit acc = v && (re || we) && !flt;
    bit rwe = 1'($urandom);
    logic [63:0] pct = {$urandom, $urandom};
    logic [4:0] rd = 5'($urandom);
    i_valid = v; i_mem_re = re; i_mem_we = we; i_func3 = f3; i_alu_result = a; i_write_data = wd;
    i_reg_we = rwe; i_pc_target = pct; i_rd_addr = rd; i_result_src = 3'($urandom);
    i_pc_plus4 = {$urandom, $urandom}; i_imm_ext = {$urandom, $urandom};
    #1;
    chk("stall_issue", o_stall, acc);
    chk("req_idle", o_mem_req, 0);
    @(posedge i_clk); @(negedge i_clk);
    if (acc) begin
      for (int k = 0; k <= dly; k++) begin
        chk("req_wait", o_mem_req, 1);
        chk("addr", o_mem_addr, a & ~64'h7);
        chk("mem_we", o_mem_we, we);
        chk("be", o_mem_be, model_be(a, f3));
        if (we) chk("wdata", o_mem_wdata, model_wdata(wd, f3));
        chk("bubble", o_valid, 0);
        i_mem_ready = (k == dly);
        i_mem_rdata = (k == dly) ? rdat : {$urandom, $urandom};
        #1;
        chk("stall_wait", o_stall, k != dly);
        @(posedge i_clk); @(negedge i_clk);
      end
    end
    clear_inputs();
    chk("valid", o_valid, v);
    chk("reg_we", o_reg_we, acc ? rwe : (v && rwe && !flt));
    chk("fault", o_access_fault, flt);
    chk("alu", o_alu_result, a);
    chk("pc_target", o_pc_target, pct);
    chk("rd", o_rd_addr, rd);
    chk("read_data", o_read_data, (acc && re) ? model_load(rdat, a, f3) : 64'h0);
    chk("req_done", o_mem_req, 0);
  endtask
  initial begin
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_stall", o_stall, 0);
    @(negedge i_clk); i_arst = 0;
    @(negedge i_clk);
    run(1, 0, 0, 3'd0, 64'h1234, 0, 0, 0);
    run(1, 1, 0, 3'b000, 64'h1003, 0, 64'h00000000_80000000, 0);
    run(1, 1, 0, 3'b100, 64'h1003, 0, 64'h00000000_80000000, 0);
    run(1, 0, 1, 3'b001, 64'h2006, 64'hABCD, 0, 3);
    run(1, 1, 0, 3'b010, 64'h3002, 0, 0, 0);
    run(1, 1, 1, 3'b011, 64'h3000, 0, 0, 0);
    run(1, 1, 0, 3'b111, 64'h3008, 0, 0, 0);
    run(1, 0, 1, 3'b100, 64'h3008, 0, 0, 0);
    // Reset in the middle of an ld access.
    i_valid = 1; i_mem_re = 1; i_func3 = 3'b011; i_alu_result = 64'h4000; i_reg_we = 1;
    @(posedge i_clk); @(negedge i_clk);
    chk("rst_wait_req", o_mem_req, 1);
    i_arst = 1;
    #1;
    chk("abort_req", o_mem_req, 0);
    chk("abort_stall", o_stall, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_be", o_mem_be, 0);
    @(negedge i_clk);
    clear_inputs(); i_arst = 0;
    @(negedge i_clk);
    i_mem_ready = 1; i_mem_rdata = 64'hDEAD;
    #1;
    chk("stray_req", o_mem_req, 0);
    @(posedge i_clk); @(negedge i_clk);
    i_mem_ready = 0;
    chk("stray_valid", o_valid, 0);
    chk("stray_rdata", o_read_data, 0);
    run(1, 0, 0, 3'd0, 64'h55, 0, 0, 0);
    for (int t = 0; t < 200; t++) begin
      int sel = int'($urandom % 8);
      logic [63:0] a = {$urandom, $urandom};
      if ($urandom % 2 == 0) a[2:0] = 3'($urandom % 2) * 3'(4 >> ($urandom % 3));
      run(($urandom % 8) != 0, sel inside {[2:4], 7}, sel inside {[5:7]}, 3'($urandom), a,
          {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom % 4));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
